alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Control sequencer for the datapath's register-to-register ALU instructions. It accepts one operation request (opcode plus destination/source register indices) and drives the datapath control strobes through the T3–T6 execution steps: source-to-Y, ALU-to-Z, then Z write-back to the destination register or to HI/LO. It sits between the instruction decode/control unit and the `datapath` control inputs, replacing hand-sequenced strobes.

## Interface
Parameters:
- `MUL_OP`, 5'b01111: ALU opcode producing a 64-bit product, written to HI/LO.
- `DIV_OP`, 5'b10000: ALU opcode producing quotient and remainder, written to HI/LO.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `clr` in 1: reset, asynchronous, active-low.
- `start` in 1: request strobe; sampled only in IDLE or DONE.
- `opcode` in 5: ALU operation; latched on accept.
- `ra` in 4: destination register index; latched on accept.
- `rb` in 4: first source index, routed to Y; latched on accept.
- `rc` in 4: second source index, driven on the bus in T4; latched on accept.
- `Rout` out 16: one-hot register bus-drive enables; bit n drives Rn.
- `Rin` out 16: one-hot register load enables.
- `Yin`, `ZHIin`, `ZLOin`, `ZLOout`, `ZHIout`, `Loin`, `HIin` out 1 each: datapath strobes.
- `ALU_opcode` out 5: opcode presented to the ALU.
- `busy` out 1: high in T3–T6.
- `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, T3, T4, T5, T6, DONE. Moore outputs are decoded from the registered state and latched operands only.
- IDLE: all outputs 0. `start`=1 latches opcode/ra/rb/rc, then next state is T3.
- T3: `Rout[rb]`=1, `Yin`=1. Next state is T4.
- T4: `Rout[rc]`=1, `ALU_opcode`=latched opcode, `ZLOin`=`ZHIin`=1. Next state is T5.
- T5, wide op (opcode is MUL_OP or DIV_OP): `ZLOout`=1, `Loin`=1. Next state is T6.
- T5, other ops: `ZLOout`=1, `Rin[ra]`=1. Next state is DONE.
- T6: `ZHIout`=1, `HIin`=1. Next state is DONE.
- DONE: `done`=1. If `start`=1, latch the new request and go to T3 (back-to-back). Otherwise go to IDLE.
- `ALU_opcode` is 0 in every state except T4.
- `start` is ignored in T3–T6, with no queuing.
- `rb`==`rc` is legal: the same register is driven in T3 and T4.
- `ra`==`rb` or `ra`==`rc` is legal: the write occurs only in T5, after both reads.
- At most one bit of `Rout` and at most one bit of `Rin` is set in any cycle. The bus driver count is ≤1 in every state.

## Timing
- Reset (`clr`=0, asynchronous): state is IDLE and every output is 0, including `busy`, `done` and `ALU_opcode`. Latched operands clear to 0.
- Reset asserted mid-operation aborts immediately with no partial pulses. The first request after release is sampled on the first rising edge with `clr`=1.
- Latency, start accepted at edge 0:
  - Normal op: T3 in cycle 1, T4 in cycle 2, T5 in cycle 3, `done` in cycle 4.
  - Wide op: T6 in cycle 4, `done` in cycle 5.
- Throughput with back-to-back starts: 4 cycles per normal op, 5 per wide op.
- Each strobe is high for exactly one full clock cycle and changes only after a rising edge.

## Configuration
- `ALU_SEQ_WIDE_EN` defined: MUL_OP and DIV_OP take the T5 (LO) plus T6 (HI) path as specified above.
- `ALU_SEQ_WIDE_EN` undefined: no opcode is wide. MUL/DIV write ZLO to `Rin[ra]` in T5 and finish without T6. `HIin`, `Loin` and `ZHIout` are tied to 0. `ZHIin` is still pulsed in T4.

## Test plan
- Reset: hold `clr`=0 with `start`=1 → all outputs 0, `busy`=0 for the whole reset.
- ADD opcode 5'b00011, ra=2, rb=6, rc=7:
  - Cycle 1: `Rout`=16'h0040, `Yin`=1.
  - Cycle 2: `Rout`=16'h0080, `ALU_opcode`=3, Z strobes high.
  - Cycle 3: `ZLOout`=1, `Rin`=16'h0004.
  - Cycle 4: `done`=1.
- DIV (5'b10000), rb=6, rc=7, macro defined:
  - Cycle 3: `ZLOout`=1, `Loin`=1.
  - Cycle 4: `ZHIout`=1, `HIin`=1.
  - Cycle 5: `done`=1. `Rin` stays 0 throughout.
- Same DIV with macro undefined → cycle 3 `Rin`=16'h0001 (ra=0), `done` in cycle 4, `HIin`/`Loin` never high.
- `start` held high for 12 cycles with a normal op → `done` in cycles 4, 8, 12. A second `start` pulse during T4 is ignored.
- `clr` pulsed low during T4 of a DIV → outputs 0 immediately. Then start ADD ra=1 → completes normally, `HIin` never asserted.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Control sequencer for register-to-register ALU instructions.
// Accepts one request (opcode, ra, rb, rc) and steps the datapath strobes through
// T3 (rb -> Y), T4 (rc on bus, ALU -> Z), T5 (ZLO write-back) and, for wide ops,
// T6 (ZHI -> HI).
// Optional feature macro: ALU_SEQ_WIDE_EN. When defined, MUL_OP/DIV_OP write LO in T5
// and HI in T6. When undefined, every opcode writes ZLO to Rin[ra] in T5 and the
// HI/LO strobes are tied low.
module alu_op_sequencer #(
  parameter logic [4:0] MUL_OP = 5'b01111,
  parameter logic [4:0] DIV_OP = 5'b10000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [4:0]  opcode,
  input  logic [3:0]  ra,
  input  logic [3:0]  rb,
  input  logic [3:0]  rc,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic        Yin,
  output logic        ZHIin,
  output logic        ZLOin,
  output logic        ZLOout,
  output logic        ZHIout,
  output logic        Loin,
  output logic        HIin,
  output logic [4:0]  ALU_opcode,
  output logic        busy,
  output logic        done
);

`ifdef ALU_SEQ_WIDE_EN
  localparam logic WideEn = 1'b1;
`else
  localparam logic WideEn = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StT3, StT4, StT5, StT6, StDone} state_e;

  state_e     state_q, state_d;
  logic [4:0] opcode_q, opcode_d;
  logic [3:0] ra_q, ra_d;
  logic [3:0] rb_q, rb_d;
  logic [3:0] rc_q, rc_d;
  logic       accept;
  logic       wide_op;

  // A request is only taken when no operation is in flight.
  assign accept  = start && ((state_q == StIdle) || (state_q == StDone));
  assign wide_op = WideEn && ((opcode_q == MUL_OP) || (opcode_q == DIV_OP));

  // Next-state and operand latch.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    rc_d     = rc_q;
    if (accept) begin
      opcode_d = opcode;
      ra_d     = ra;
      rb_d     = rb;
      rc_d     = rc;
    end
    unique case (state_q)
      StIdle:  if (start) state_d = StT3;
      StT3:    state_d = StT4;
      StT4:    state_d = StT5;
      StT5:    state_d = wide_op ? StT6 : StDone;
      StT6:    state_d = StDone;
      StDone:  state_d = start ? StT3 : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Moore output decode from registered state and latched operands only.
  always_comb begin
    Rout       = '0;
    Rin        = '0;
    Yin        = 1'b0;
    ZHIin      = 1'b0;
    ZLOin      = 1'b0;
    ZLOout     = 1'b0;
    ZHIout     = 1'b0;
    Loin       = 1'b0;
    HIin       = 1'b0;
    ALU_opcode = '0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      StT3: begin
        Rout = 16'd1 << rb_q;
        Yin  = 1'b1;
        busy = 1'b1;
      end
      StT4: begin
        Rout       = 16'd1 << rc_q;
        ALU_opcode = opcode_q;
        ZLOin      = 1'b1;
        ZHIin      = 1'b1;
        busy       = 1'b1;
      end
      StT5: begin
        ZLOout = 1'b1;
        busy   = 1'b1;
        // Destination write happens only here, after both source reads.
        if (wide_op) Loin = 1'b1;
        else         Rin  = 16'd1 << ra_q;
      end
      StT6: begin
        ZHIout = 1'b1;
        HIin   = 1'b1;
        busy   = 1'b1;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
    // HI/LO path is absent when the wide feature is not built in.
    if (!WideEn) begin
      ZHIout = 1'b0;
      Loin   = 1'b0;
      HIin   = 1'b0;
    end
  end

  // State and operand registers; async reset aborts any operation in flight.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= StIdle;
      opcode_q <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      rc_q     <= rc_d;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: each request pushes its per-cycle expected
// strobe snapshots; every cycle one snapshot is popped (idle if the queue is empty)
// and compared against the DUT outputs sampled on the falling edge.
module tb_alu_op_sequencer;

`ifdef ALU_SEQ_WIDE_EN
  localparam bit WideEn = 1'b1;
`else
  localparam bit WideEn = 1'b0;
`endif

  localparam logic [4:0] OpAdd = 5'b00011;
  localparam logic [4:0] OpMul = 5'b01111;
  localparam logic [4:0] OpDiv = 5'b10000;

  typedef struct packed {
    logic [15:0] rout;
    logic [15:0] rin;
    logic        yin;
    logic        zhiin;
    logic        zloin;
    logic        zloout;
    logic        zhiout;
    logic        loin;
    logic        hiin;
    logic [4:0]  alu;
    logic        busy;
    logic        done;
  } snap_t;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic [15:0] Rout, Rin;
  logic        Yin, ZHIin, ZLOin, ZLOout, ZHIout, Loin, HIin;
  logic [4:0]  ALU_opcode;
  logic        busy, done;

  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  snap_t exp_q[$];

  alu_op_sequencer dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .opcode     (opcode),
    .ra         (ra),
    .rb         (rb),
    .rc         (rc),
    .Rout       (Rout),
    .Rin        (Rin),
    .Yin        (Yin),
    .ZHIin      (ZHIin),
    .ZLOin      (ZLOin),
    .ZLOout     (ZLOout),
    .ZHIout     (ZHIout),
    .Loin       (Loin),
    .HIin       (HIin),
    .ALU_opcode (ALU_opcode),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic snap_t observed();
    snap_t s;
    s.rout   = Rout;
    s.rin    = Rin;
    s.yin    = Yin;
    s.zhiin  = ZHIin;
    s.zloin  = ZLOin;
    s.zloout = ZLOout;
    s.zhiout = ZHIout;
    s.loin   = Loin;
    s.hiin   = HIin;
    s.alu    = ALU_opcode;
    s.busy   = busy;
    s.done   = done;
    return s;
  endfunction

  // Expected strobe sequence of one request, straight from the step table.
  task automatic push_op(input logic [4:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c);
    snap_t s;
    bit    wide;
    wide = WideEn && ((op == OpMul) || (op == OpDiv));
    s = '0; s.rout = 16'd1 << b; s.yin = 1'b1; s.busy = 1'b1;
    exp_q.push_back(s);
    s = '0; s.rout = 16'd1 << c; s.alu = op; s.zloin = 1'b1; s.zhiin = 1'b1; s.busy = 1'b1;
    exp_q.push_back(s);
    s = '0; s.zloout = 1'b1; s.busy = 1'b1;
    if (wide) s.loin = 1'b1;
    else      s.rin  = 16'd1 << a;
    exp_q.push_back(s);
    if (wide) begin
      s = '0; s.zhiout = 1'b1; s.hiin = 1'b1; s.busy = 1'b1;
      exp_q.push_back(s);
    end
    s = '0; s.done = 1'b1;
    exp_q.push_back(s);
  endtask

  task automatic issue(input logic [4:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c);
    opcode = op; ra = a; rb = b; rc = c;
    start  = 1'b1;
    push_op(op, a, b, c);
  endtask

  task automatic step(input string tag);
    snap_t e;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : snap_t'('0);
    check_eq(tag, 64'(observed()), 64'(e));
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    int div_len;
    div_len = WideEn ? 5 : 4;
    clr = 1'b0; start = 1'b1; opcode = OpDiv; ra = 4'd3; rb = 4'd4; rc = 4'd5;
    #1 check_eq("reset_t0", 64'(observed()), 64'd0);
    run(3, "reset_hold");
    @(negedge clk);
    start = 1'b0; clr = 1'b1;
    run(2, "idle");

    // ADD ra=2 rb=6 rc=7.
    issue(OpAdd, 4'd2, 4'd6, 4'd7);
    step("add");
    start = 1'b0;
    run(4, "add");

    // DIV ra=0 rb=6 rc=7.
    issue(OpDiv, 4'd0, 4'd6, 4'd7);
    step("div");
    start = 1'b0;
    run(5, "div");

    // MUL with all indices aliased.
    issue(OpMul, 4'd5, 4'd5, 4'd5);
    step("mul_alias");
    start = 1'b0;
    run(5, "mul_alias");

    // Start held for 12 cycles: three back-to-back normal ops.
    opcode = 5'b00001; ra = 4'd1; rb = 4'd3; rc = 4'd4; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push_op(5'b00001, 4'd1, 4'd3, 4'd4);
      run(4, "b2b");
    end
    start = 1'b0;
    step("b2b_end");

    // Second start during T4 is ignored, operand changes must not leak.
    issue(OpAdd, 4'd9, 4'd10, 4'd11);
    step("ign_t3");
    start = 1'b0;
    step("ign_t4");
    start = 1'b1; opcode = OpDiv; ra = 4'd1; rb = 4'd2; rc = 4'd3;
    step("ign_t5");
    start = 1'b0;
    run(3, "ign_tail");

    // Wide op followed back-to-back by a normal op.
    issue(OpDiv, 4'd8, 4'd12, 4'd13);
    run(div_len, "div_b2b");
    opcode = OpAdd; ra = 4'd14; rb = 4'd15; rc = 4'd0;
    push_op(OpAdd, 4'd14, 4'd15, 4'd0);
    step("add_b2b");
    start = 1'b0;
    run(4, "add_b2b");

    // Reset during T4 of a DIV aborts at once, then a clean ADD.
    issue(OpDiv, 4'd0, 4'd6, 4'd7);
    step("abort_t3");
    start = 1'b0;
    step("abort_t4");
    clr = 1'b0;
    #1 check_eq("abort_now", 64'(observed()), 64'd0);
    exp_q.delete();
    run(2, "abort_hold");
    clr = 1'b1;
    issue(OpAdd, 4'd1, 4'd2, 4'd3);
    step("post_abort");
    start = 1'b0;
    run(4, "post_abort");

    check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
